// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - ID/EX issue register with issued-destination history, forward selects and load-use interlock
module id_issue_ctrl #(
  parameter  int PAYLOAD_W = 96,
  parameter  int NREGS     = 32,
  parameter  int FWD_DEPTH = 3,
  localparam int AW        = $clog2(NREGS),
  localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [PAYLOAD_W-1:0] id_payload_i,
  input  logic [AW-1:0]        id_rs1_i,
  input  logic [AW-1:0]        id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [AW-1:0]        id_rd_i,
  input  logic                 id_we_i,
  input  logic                 id_load_i,
  input  logic                 flush_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [PAYLOAD_W-1:0] ex_payload_o,
  output logic [AW-1:0]        ex_rd_o,
  output logic                 ex_we_o,
  output logic [SW-1:0]        ex_fwd_a_sel_o,
  output logic [SW-1:0]        ex_fwd_b_sel_o,
  output logic [15:0]          load_use_cnt_o
);

  logic                 r_occ;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [AW-1:0]        r_rs1;
  logic [AW-1:0]        r_rs2;
  logic                 r_use1;
  logic                 r_use2;
  logic [AW-1:0]        r_rd;
  logic                 r_we;
  logic                 r_load;

  logic                 r_hv    [FWD_DEPTH];
  logic [AW-1:0]        r_hrd   [FWD_DEPTH];
  logic                 r_hwe   [FWD_DEPTH];
  logic                 r_hload [FWD_DEPTH];

  logic [15:0]          r_cnt;

  logic [SW-1:0]        w_sel_a;
  logic [SW-1:0]        w_sel_b;
  logic                 w_m0_a;
  logic                 w_m0_b;
  logic                 w_load_use;
  logic                 w_ex_valid;
  logic                 w_issued;
  logic                 w_id_ready;
  logic                 w_accept;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (r_use1 && (r_rs1 != '0) && r_hv[k] && r_hwe[k] && (r_hrd[k] == r_rs1))
        w_sel_a = SW'(k + 1);
      if (r_use2 && (r_rs2 != '0) && r_hv[k] && r_hwe[k] && (r_hrd[k] == r_rs2))
        w_sel_b = SW'(k + 1);
    end
  end

  always_comb begin
    w_m0_a     = r_use1 && (r_rs1 != '0) && r_hv[0] && r_hwe[0] && (r_hrd[0] == r_rs1);
    w_m0_b     = r_use2 && (r_rs2 != '0) && r_hv[0] && r_hwe[0] && (r_hrd[0] == r_rs2);
    w_load_use = (w_m0_a || w_m0_b) && r_hload[0];
    w_ex_valid = r_occ && !w_load_use && !flush_i;
    w_issued   = w_ex_valid && ex_ready_i;
    w_id_ready = !flush_i && (!r_occ || w_issued);
    w_accept   = id_valid_i && w_id_ready;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_occ     <= 1'b0;
      r_payload <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_use1    <= 1'b0;
      r_use2    <= 1'b0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      if (flush_i) begin
        r_occ <= 1'b0;
      end else if (w_accept) begin
        r_occ     <= 1'b1;
        r_payload <= id_payload_i;
        r_rs1     <= id_rs1_i;
        r_rs2     <= id_rs2_i;
        r_use1    <= id_use_rs1_i;
        r_use2    <= id_use_rs2_i;
        r_rd      <= id_rd_i;
        r_we      <= id_we_i;
        r_load    <= id_load_i;
      end else if (w_issued) begin
        r_occ <= 1'b0;
      end
    end
  end

  // History advances only when the back end does; a non-issue cycle shifts in a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        r_hv[k]    <= 1'b0;
        r_hrd[k]   <= '0;
        r_hwe[k]   <= 1'b0;
        r_hload[k] <= 1'b0;
      end
    end else if (ex_ready_i) begin
      r_hv[0]    <= w_issued;
      r_hrd[0]   <= w_issued ? r_rd : '0;
      r_hwe[0]   <= w_issued && r_we;
      r_hload[0] <= w_issued && r_load;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        r_hv[k]    <= r_hv[k-1];
        r_hrd[k]   <= r_hrd[k-1];
        r_hwe[k]   <= r_hwe[k-1];
        r_hload[k] <= r_hload[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (r_occ && w_load_use && ex_ready_i && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign id_ready_o     = w_id_ready;
  assign ex_valid_o     = w_ex_valid;
  assign ex_payload_o   = r_payload;
  assign ex_rd_o        = r_rd;
  assign ex_we_o        = r_we;
  assign ex_fwd_a_sel_o = w_sel_a;
  assign ex_fwd_b_sel_o = w_sel_b;
  assign load_use_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb/tb_id_issue_ctrl.sv - directed self-checking bench for id_issue_ctrl
module tb_id_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [95:0] id_payload_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_we_i;
  logic        id_load_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [95:0] ex_payload_o;
  logic [4:0]  ex_rd_o;
  logic        ex_we_o;
  logic [1:0]  ex_fwd_a_sel_o;
  logic [1:0]  ex_fwd_b_sel_o;
  logic [15:0] load_use_cnt_o;

  int checks = 0;
  int passed = 0;

  id_issue_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_ready_o     (id_ready_o),
    .id_payload_i   (id_payload_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_use_rs1_i   (id_use_rs1_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .id_rd_i        (id_rd_i),
    .id_we_i        (id_we_i),
    .id_load_i      (id_load_i),
    .flush_i        (flush_i),
    .ex_valid_o     (ex_valid_o),
    .ex_ready_i     (ex_ready_i),
    .ex_payload_o   (ex_payload_o),
    .ex_rd_o        (ex_rd_o),
    .ex_we_o        (ex_we_o),
    .ex_fwd_a_sel_o (ex_fwd_a_sel_o),
    .ex_fwd_b_sel_o (ex_fwd_b_sel_o),
    .load_use_cnt_o (load_use_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic we, input logic ld, input logic [95:0] pl);
    id_valid_i   = v;
    id_rd_i      = rd;
    id_rs1_i     = rs1;
    id_rs2_i     = rs2;
    id_use_rs1_i = u1;
    id_use_rs2_i = u2;
    id_we_i      = we;
    id_load_i    = ld;
    id_payload_i = pl;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 96'h0);
  endtask

  // Producer of x<p>, n independent instructions, then a consumer of x<p> on both operands.
  task automatic gap(input int n, input logic [4:0] p, input logic [1:0] exp_sel);
    next_cycle();
    set_in(1'b1, p, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'(p));
    for (int i = 0; i < n; i++) begin
      next_cycle();
      set_in(1'b1, 5'(20 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'(100 + i));
    end
    next_cycle();
    set_in(1'b1, 5'd0, p, p, 1'b1, 1'b1, 1'b0, 1'b0, 96'h5A5A);
    next_cycle();
    idle();
    #1;
    check($sformatf("gap%0d_valid", n), ex_valid_o, 1'b1);
    check($sformatf("gap%0d_sel_a", n), ex_fwd_a_sel_o, exp_sel);
    check($sformatf("gap%0d_sel_b", n), ex_fwd_b_sel_o, exp_sel);
  endtask

  initial begin
    rst_i      = 1'b0;
    flush_i    = 1'b0;
    ex_ready_i = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    check("rst_valid", ex_valid_o, 1'b0);
    check("rst_ready", id_ready_o, 1'b1);
    check("rst_sel_a", ex_fwd_a_sel_o, 2'd0);
    check("rst_sel_b", ex_fwd_b_sel_o, 2'd0);
    check("rst_payload", ex_payload_o, 96'h0);
    check("rst_rd", ex_rd_o, 5'd0);
    check("rst_we", ex_we_o, 1'b0);
    check("rst_cnt", load_use_cnt_o, 16'd0);
    rst_i = 1'b1;

    // Back-to-back dependency: ADD x5 then SUB x6,x5,x5
    set_in(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 96'hA1);
    next_cycle();
    set_in(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 96'hA2);
    #1;
    check("add_valid", ex_valid_o, 1'b1);
    check("add_payload", ex_payload_o, 96'hA1);
    check("add_rd", ex_rd_o, 5'd5);
    check("add_sel_a", ex_fwd_a_sel_o, 2'd0);
    next_cycle();
    idle();
    #1;
    check("sub_valid", ex_valid_o, 1'b1);
    check("sub_payload", ex_payload_o, 96'hA2);
    check("sub_sel_a", ex_fwd_a_sel_o, 2'd1);
    check("sub_sel_b", ex_fwd_b_sel_o, 2'd1);

    gap(1, 5'd16, 2'd2);
    gap(2, 5'd17, 2'd3);
    gap(3, 5'd18, 2'd0);

    // Load-use: LW x7 then ADD x8,x7,x0
    next_cycle();
    set_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 96'hB1);
    next_cycle();
    set_in(1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 96'hB2);
    #1;
    check("lw_valid", ex_valid_o, 1'b1);
    next_cycle();
    idle();
    #1;
    check("lu_bubble_valid", ex_valid_o, 1'b0);
    check("lu_bubble_ready", id_ready_o, 1'b0);
    check("lu_bubble_cnt", load_use_cnt_o, 16'd0);
    next_cycle();
    #1;
    check("lu_issue_valid", ex_valid_o, 1'b1);
    check("lu_issue_payload", ex_payload_o, 96'hB2);
    check("lu_sel_a", ex_fwd_a_sel_o, 2'd2);
    check("lu_sel_b", ex_fwd_b_sel_o, 2'd0);
    check("lu_cnt", load_use_cnt_o, 16'd1);

    // x0 destination and consumer of x0
    next_cycle();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'hC1);
    next_cycle();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 96'hC2);
    next_cycle();
    idle();
    #1;
    check("x0_valid", ex_valid_o, 1'b1);
    check("x0_sel_a", ex_fwd_a_sel_o, 2'd0);
    check("x0_sel_b", ex_fwd_b_sel_o, 2'd0);

    // Unused rs2 naming a pending rd
    next_cycle();
    set_in(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'hD1);
    next_cycle();
    set_in(1'b1, 5'd0, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 96'hD2);
    next_cycle();
    idle();
    #1;
    check("unused_valid", ex_valid_o, 1'b1);
    check("unused_sel_a", ex_fwd_a_sel_o, 2'd0);
    check("unused_sel_b", ex_fwd_b_sel_o, 2'd0);

    // Back-pressure for 4 cycles on a dependent instruction
    next_cycle();
    set_in(1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'hE1);
    next_cycle();
    set_in(1'b1, 5'd0, 5'd13, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 96'hE2);
    next_cycle();
    idle();
    ex_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d_valid", i), ex_valid_o, 1'b1);
      check($sformatf("bp%0d_payload", i), ex_payload_o, 96'hE2);
      check($sformatf("bp%0d_ready", i), id_ready_o, 1'b0);
      check($sformatf("bp%0d_sel_a", i), ex_fwd_a_sel_o, 2'd1);
      if (i < 3) begin
        next_cycle();
        #1;
      end
    end
    next_cycle();
    ex_ready_i = 1'b1;
    #1;
    check("bp_rel_valid", ex_valid_o, 1'b1);
    check("bp_rel_sel_a", ex_fwd_a_sel_o, 2'd1);
    check("bp_rel_ready", id_ready_o, 1'b1);

    // Flush with a held instruction and a same-cycle ID input
    next_cycle();
    set_in(1'b1, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'hF1);
    next_cycle();
    set_in(1'b1, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'hF2);
    next_cycle();
    set_in(1'b1, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'hF3);
    flush_i = 1'b1;
    #1;
    check("fl_valid", ex_valid_o, 1'b0);
    check("fl_ready", id_ready_o, 1'b0);
    next_cycle();
    flush_i = 1'b0;
    set_in(1'b1, 5'd0, 5'd14, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 96'hF4);
    #1;
    check("fl_after_valid", ex_valid_o, 1'b0);
    next_cycle();
    idle();
    #1;
    check("fl_dep_valid", ex_valid_o, 1'b1);
    check("fl_dep_payload", ex_payload_o, 96'hF4);
    check("fl_dep_sel_a", ex_fwd_a_sel_o, 2'd3);
    check("fl_dep_sel_b", ex_fwd_b_sel_o, 2'd0);

    // Asynchronous reset mid-stream
    next_cycle();
    set_in(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'h91);
    next_cycle();
    set_in(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 96'h93);
    next_cycle();
    idle();
    #1;
    check("pre_rst_valid", ex_valid_o, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", ex_valid_o, 1'b0);
    check("mid_rst_cnt", load_use_cnt_o, 16'd0);
    check("mid_rst_ready", id_ready_o, 1'b1);
    check("mid_rst_payload", ex_payload_o, 96'h0);
    #1;
    rst_i = 1'b1;
    next_cycle();
    set_in(1'b1, 5'd0, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 96'h92);
    next_cycle();
    idle();
    #1;
    check("post_rst_valid", ex_valid_o, 1'b1);
    check("post_rst_payload", ex_payload_o, 96'h92);
    check("post_rst_sel_a", ex_fwd_a_sel_o, 2'd0);
    check("post_rst_sel_b", ex_fwd_b_sel_o, 2'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
